// File: rtl/rpn_stack_alu.sv
`default_nettype none
// ============================================================================
//  Module      : rpn_stack_alu
//  Description : RPN arithmetic unit. Parses an ASCII decimal character stream
//                onto a DEPTH-entry stack of WIDTH-bit signed words, executes
//                + - * /, and on '=' emits the popped result as signed decimal
//                ASCII followed by a newline. Errors emit "E\n".
//  Revision    : 1.0 - initial release
// ============================================================================
module rpn_stack_alu #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         in_stb_i,
    input  logic [7:0]                   in_char_i,
    output logic                         in_ack_o,
    output logic                         out_stb_o,
    output logic [7:0]                   out_char_o,
    input  logic                         out_ack_i,
    output logic                         err_o,
    output logic [$clog2(DEPTH+1)-1:0]   depth_o
);

    localparam int c_DW   = $clog2(DEPTH + 1);
    localparam int c_AW   = $clog2(DEPTH);
    // Decimal digits needed for the largest unsigned WIDTH-bit magnitude
    localparam int c_NDIG = (WIDTH * 30103) / 100000 + 1;
    localparam int c_IW   = $clog2(c_NDIG);

    localparam logic [WIDTH-1:0] c_TEN = WIDTH'(10);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_EXEC     = 3'd1;
    localparam logic [2:0] c_ST_CONV     = 3'd2;
    localparam logic [2:0] c_ST_EMIT_SGN = 3'd3;
    localparam logic [2:0] c_ST_EMIT_DIG = 3'd4;
    localparam logic [2:0] c_ST_EMIT_NL  = 3'd5;
    localparam logic [2:0] c_ST_EMIT_ERR = 3'd6;
    localparam logic [2:0] c_ST_ERR_NL   = 3'd7;

    localparam logic [1:0] c_OP_ADD = 2'd0;
    localparam logic [1:0] c_OP_SUB = 2'd1;
    localparam logic [1:0] c_OP_MUL = 2'd2;
    localparam logic [1:0] c_OP_DIV = 2'd3;

    logic [2:0]        state_q, state_d;
    logic [WIDTH-1:0]  stk_q [DEPTH];
    logic [WIDTH-1:0]  stk_d [DEPTH];
    logic [c_DW-1:0]   sp_q, sp_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              pend_q, pend_d;
    logic              err_q, err_d;
    logic [1:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic [3:0]        dig_q [c_NDIG];
    logic [3:0]        dig_d [c_NDIG];
    logic [c_IW-1:0]   idx_q, idx_d;

    logic              w_is_digit;
    logic              w_is_op;
    logic [1:0]        w_op_code;
    logic              w_full;
    logic              w_eff_lt2;
    logic [c_AW-1:0]   w_push_idx;
    logic [c_AW-1:0]   w_top_idx;
    logic [c_AW-1:0]   w_sec_idx;
    logic [WIDTH-1:0]  w_top_val;
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic [WIDTH-1:0]  w_abs_a;
    logic [WIDTH-1:0]  w_abs_b;
    logic [WIDTH-1:0]  w_uquo;
    logic [WIDTH-1:0]  w_quo;
    logic [WIDTH-1:0]  w_res;
    logic [WIDTH-1:0]  w_quot10;
    logic              w_fail;

    // Character classification and stack addressing
    assign w_is_digit = (in_char_i >= 8'h30) && (in_char_i <= 8'h39);
    assign w_is_op    = (in_char_i == 8'h2B) || (in_char_i == 8'h2D) ||
                        (in_char_i == 8'h2A) || (in_char_i == 8'h2F);
    assign w_full     = (sp_q == c_DW'(DEPTH));
    assign w_eff_lt2  = ((sp_q + c_DW'(pend_q)) < c_DW'(2));
    assign w_push_idx = c_AW'(sp_q);
    assign w_top_idx  = c_AW'(sp_q - c_DW'(1));
    assign w_sec_idx  = c_AW'(sp_q - c_DW'(2));
    assign w_top_val  = pend_q ? acc_q : stk_q[w_top_idx];

    // Operand fetch and signed division via magnitudes (MIN / -1 wraps to MIN)
    assign w_a      = stk_q[w_sec_idx];
    assign w_b      = stk_q[w_top_idx];
    assign w_abs_a  = w_a[WIDTH-1] ? (-w_a) : w_a;
    assign w_abs_b  = w_b[WIDTH-1] ? (-w_b) : w_b;
    assign w_uquo   = (w_abs_b == '0) ? '0 : (w_abs_a / w_abs_b);
    assign w_quo    = (w_a[WIDTH-1] ^ w_b[WIDTH-1]) ? (-w_uquo) : w_uquo;
    assign w_quot10 = mag_q / c_TEN;

    // Operator encoding of the incoming character
    always_comb begin
        w_op_code = c_OP_ADD;
        case (in_char_i)
            8'h2D:   w_op_code = c_OP_SUB;
            8'h2A:   w_op_code = c_OP_MUL;
            8'h2F:   w_op_code = c_OP_DIV;
            default: w_op_code = c_OP_ADD;
        endcase
    end

    // ALU result for the latched operator
    always_comb begin
        w_res = w_a + w_b;
        case (op_q)
            c_OP_SUB: w_res = w_a - w_b;
            c_OP_MUL: w_res = w_a * w_b;
            c_OP_DIV: w_res = w_quo;
            default:  w_res = w_a + w_b;
        endcase
    end

    // Next-state logic: parser, executor, converter and emitter
    always_comb begin
        state_d = state_q;
        stk_d   = stk_q;
        sp_d    = sp_q;
        acc_d   = acc_q;
        pend_d  = pend_q;
        err_d   = err_q;
        op_d    = op_q;
        neg_d   = neg_q;
        mag_d   = mag_q;
        dig_d   = dig_q;
        idx_d   = idx_q;
        w_fail  = 1'b0;

        case (state_q)
            c_ST_IDLE: begin
                if (in_stb_i) begin
                    err_d = 1'b0;
                    if (w_is_digit) begin
                        acc_d  = acc_q * c_TEN + WIDTH'(in_char_i[3:0]);
                        pend_d = 1'b1;
                    end else if (in_char_i == 8'h20) begin
                        if (pend_q) begin
                            if (w_full) begin
                                w_fail = 1'b1;
                            end else begin
                                stk_d[w_push_idx] = acc_q;
                                sp_d   = sp_q + c_DW'(1);
                                acc_d  = '0;
                                pend_d = 1'b0;
                            end
                        end
                    end else if ((in_char_i == 8'h28) || (in_char_i == 8'h29)) begin
                        // Brackets carry no meaning in RPN; accepted and dropped
                    end else if (w_is_op) begin
                        if (pend_q && w_full) begin
                            w_fail = 1'b1;
                        end else if (w_eff_lt2) begin
                            w_fail = 1'b1;
                        end else begin
                            if (pend_q) begin
                                stk_d[w_push_idx] = acc_q;
                                sp_d   = sp_q + c_DW'(1);
                                acc_d  = '0;
                                pend_d = 1'b0;
                            end
                            op_d    = w_op_code;
                            state_d = c_ST_EXEC;
                        end
                    end else if (in_char_i == 8'h3D) begin
                        if (pend_q && w_full) begin
                            w_fail = 1'b1;
                        end else if (!pend_q && (sp_q == '0)) begin
                            w_fail = 1'b1;
                        end else begin
                            // A pending literal is pushed and popped at once,
                            // so it feeds conversion without touching the stack
                            if (!pend_q) begin
                                sp_d = sp_q - c_DW'(1);
                            end
                            neg_d   = w_top_val[WIDTH-1];
                            mag_d   = w_top_val[WIDTH-1] ? (-w_top_val) : w_top_val;
                            acc_d   = '0;
                            pend_d  = 1'b0;
                            idx_d   = '0;
                            state_d = c_ST_CONV;
                        end
                    end else begin
                        w_fail = 1'b1;
                    end
                end
            end

            c_ST_EXEC: begin
                if ((op_q == c_OP_DIV) && (w_b == '0)) begin
                    w_fail = 1'b1;
                end else begin
                    stk_d[w_sec_idx] = w_res;
                    sp_d    = sp_q - c_DW'(1);
                    state_d = c_ST_IDLE;
                end
            end

            c_ST_CONV: begin
                // Least significant digit first; idx ends on the MS digit
                dig_d[idx_q] = 4'(mag_q % c_TEN);
                mag_d        = w_quot10;
                if (w_quot10 == '0) begin
                    state_d = neg_q ? c_ST_EMIT_SGN : c_ST_EMIT_DIG;
                end else begin
                    idx_d = idx_q + c_IW'(1);
                end
            end

            c_ST_EMIT_SGN: begin
                if (out_ack_i) state_d = c_ST_EMIT_DIG;
            end

            c_ST_EMIT_DIG: begin
                if (out_ack_i) begin
                    if (idx_q == '0) begin
                        state_d = c_ST_EMIT_NL;
                    end else begin
                        idx_d = idx_q - c_IW'(1);
                    end
                end
            end

            c_ST_EMIT_NL: begin
                if (out_ack_i) state_d = c_ST_IDLE;
            end

            c_ST_EMIT_ERR: begin
                if (out_ack_i) state_d = c_ST_ERR_NL;
            end

            c_ST_ERR_NL: begin
                if (out_ack_i) state_d = c_ST_IDLE;
            end

            default: state_d = c_ST_IDLE;
        endcase

        if (w_fail) begin
            err_d   = 1'b1;
            sp_d    = '0;
            acc_d   = '0;
            pend_d  = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stk_d[i] = '0;
            end
            state_d = c_ST_EMIT_ERR;
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= c_ST_IDLE;
            sp_q    <= '0;
            acc_q   <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            op_q    <= c_OP_ADD;
            neg_q   <= 1'b0;
            mag_q   <= '0;
            idx_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stk_q[i] <= '0;
            end
            for (int i = 0; i < c_NDIG; i++) begin
                dig_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            acc_q   <= acc_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            mag_q   <= mag_d;
            idx_q   <= idx_d;
            stk_q   <= stk_d;
            dig_q   <= dig_d;
        end
    end

    // Output character selection, decoded straight from state so reset
    // drops out_stb without waiting for a clock
    always_comb begin
        out_char_o = 8'h00;
        case (state_q)
            c_ST_EMIT_SGN: out_char_o = 8'h2D;
            c_ST_EMIT_DIG: out_char_o = {4'h3, dig_q[idx_q]};
            c_ST_EMIT_NL:  out_char_o = 8'h0A;
            c_ST_EMIT_ERR: out_char_o = 8'h45;
            c_ST_ERR_NL:   out_char_o = 8'h0A;
            default:       out_char_o = 8'h00;
        endcase
    end

    assign in_ack_o  = (state_q == c_ST_IDLE);
    assign out_stb_o = (state_q == c_ST_EMIT_SGN) || (state_q == c_ST_EMIT_DIG) ||
                       (state_q == c_ST_EMIT_NL)  || (state_q == c_ST_EMIT_ERR) ||
                       (state_q == c_ST_ERR_NL);
    assign err_o     = err_q;
    assign depth_o   = sp_q;

endmodule
`default_nettype wire

// File: tb/tb_rpn_stack_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rpn_stack_alu
//  Description : Self-checking bench for rpn_stack_alu against a queue-based
//                calculator model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rpn_stack_alu;

    localparam int W = 16;
    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_stb = 1'b0;
    logic [7:0] in_char = 8'h00;
    logic       in_ack;
    logic       out_stb;
    logic [7:0] out_char;
    logic       out_ack;
    logic       err;
    logic [3:0] depth;

    int   tests = 0;
    int   fails = 0;
    int   ack_mode = 0;     // 0: tied high, 1: random, 2: manual
    logic man_ack = 1'b0;
    logic rnd_ack = 1'b1;

    byte  cap_q[$];

    // Reference model state
    longint m_stk[$];
    longint m_acc = 0;
    bit     m_pend = 0;
    bit     m_err = 0;
    string  m_out = "";

    always #5 clk = ~clk;

    always @(posedge clk) rnd_ack <= 1'($urandom_range(0, 1));

    assign out_ack = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? rnd_ack : man_ack;

    rpn_stack_alu #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_stb_i   (in_stb),
        .in_char_i  (in_char),
        .in_ack_o   (in_ack),
        .out_stb_o  (out_stb),
        .out_char_o (out_char),
        .out_ack_i  (out_ack),
        .err_o      (err),
        .depth_o    (depth)
    );

    // Record every character that will transfer on the coming rising edge
    always @(negedge clk) begin
        if (rst_n && out_stb && out_ack) cap_q.push_back(out_char);
    end

    function automatic longint wrap(input longint x);
        longint m;
        longint full;
        full = longint'(1) << W;
        m = x % full;
        if (m < 0) m += full;
        if (m >= (full >> 1)) m -= full;
        return m;
    endfunction

    function automatic void m_fail();
        m_err = 1;
        m_stk.delete();
        m_acc = 0;
        m_pend = 0;
        m_out = {m_out, "E\n"};
    endfunction

    function automatic bit m_push_pending();
        if (m_pend) begin
            if (m_stk.size() == D) begin
                m_fail();
                return 0;
            end
            m_stk.push_back(m_acc);
            m_acc = 0;
            m_pend = 0;
        end
        return 1;
    endfunction

    function automatic void m_char(input byte c);
        longint a, b, r;
        m_err = 0;
        if (c >= "0" && c <= "9") begin
            m_acc = wrap(m_acc * 10 + longint'(c - "0"));
            m_pend = 1;
        end else if (c == " ") begin
            void'(m_push_pending());
        end else if (c == "(" || c == ")") begin
        end else if (c == "+" || c == "-" || c == "*" || c == "/") begin
            if (!m_push_pending()) return;
            if (m_stk.size() < 2) begin
                m_fail();
                return;
            end
            b = m_stk.pop_back();
            a = m_stk.pop_back();
            if (c == "/" && b == 0) begin
                m_fail();
                return;
            end
            case (c)
                "+":     r = a + b;
                "-":     r = a - b;
                "*":     r = a * b;
                default: r = a / b;
            endcase
            m_stk.push_back(wrap(r));
        end else if (c == "=") begin
            if (!m_push_pending()) return;
            if (m_stk.size() == 0) begin
                m_fail();
                return;
            end
            a = m_stk.pop_back();
            m_out = {m_out, $sformatf("%0d\n", a)};
        end else begin
            m_fail();
        end
    endfunction

    function automatic void m_reset();
        m_stk.delete();
        m_acc = 0;
        m_pend = 0;
        m_err = 0;
    endfunction

    function automatic string cap_str();
        string r = "";
        foreach (cap_q[i]) r = {r, $sformatf("%c", cap_q[i])};
        return r;
    endfunction

    function automatic string esc(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0A) r = {r, "\\n"};
            else r = {r, $sformatf("%c", s[i])};
        end
        return r;
    endfunction

    // Drive one character; inputs change 1 time unit after the rising edge
    task automatic send_char(input byte c);
        int n = 0;
        in_stb = 1'b1;
        in_char = c;
        while (!in_ack && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) begin
            fails++;
            $display("FAIL send_timeout: in_ack=%b for char %h, required 1", in_ack, c);
        end
        @(posedge clk); #1;
        in_stb = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ack && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) begin
            fails++;
            $display("FAIL idle_timeout: in_ack=%b, required 1", in_ack);
        end
    endtask

    task automatic run_seq(input string s);
        m_out = "";
        cap_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            m_char(s[i]);
            send_char(s[i]);
        end
        wait_idle();
    endtask

    task automatic test_reset();
        tests++;
        if (in_ack !== 1'b1) begin fails++; $display("FAIL rst_in_ack: got %b required 1", in_ack); end
        tests++;
        if (out_stb !== 1'b0) begin fails++; $display("FAIL rst_out_stb: got %b required 0", out_stb); end
        tests++;
        if (out_char !== 8'h00) begin fails++; $display("FAIL rst_out_char: got %h required 00", out_char); end
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b required 0", err); end
        tests++;
        if (depth !== 4'd0) begin fails++; $display("FAIL rst_depth: got %0d required 0", depth); end
    endtask

    task automatic test_arith();
        string seqs[6];
        string req[6];
        seqs[0] = "12 30+=";            req[0] = "42\n";
        seqs[1] = "5 7-=";              req[1] = "-2\n";
        seqs[2] = "(6 7*)=";            req[2] = "42\n";
        seqs[3] = "40000 30000+=";      req[3] = "4464\n";
        seqs[4] = "32768 0 1-/=";       req[4] = "-32768\n";
        seqs[5] = "0 7-2/=";            req[5] = "-3\n";
        for (int i = 0; i < 6; i++) begin
            run_seq(seqs[i]);
            tests++;
            if (cap_str() != req[i] || m_out != req[i]) begin
                fails++;
                $display("FAIL arith_%0d: got '%s' required '%s'", i, esc(cap_str()), esc(req[i]));
            end
            tests++;
            if (depth !== 4'd0 || err !== 1'b0) begin
                fails++;
                $display("FAIL arith_state_%0d: depth=%0d err=%b required 0/0", i, depth, err);
            end
        end
    endtask

    task automatic test_div_zero();
        run_seq("7 0/");
        tests++;
        if (cap_str() != "E\n" || err !== 1'b1 || depth !== 4'd0) begin
            fails++;
            $display("FAIL div0: got '%s' err=%b depth=%0d required 'E\\n' 1 0", esc(cap_str()), err, depth);
        end
        m_char("3");
        send_char("3");
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL err_clear: got %b required 0", err); end
        run_seq(" 4*=");
        tests++;
        if (cap_str() != "12\n") begin
            fails++;
            $display("FAIL after_err: got '%s' required '12\\n'", esc(cap_str()));
        end
    endtask

    task automatic test_overflow_underflow();
        run_seq("1 2 3 4 5 6 7 8 ");
        tests++;
        if (depth !== 4'd8) begin fails++; $display("FAIL full_depth: got %0d required 8", depth); end
        run_seq("9 ");
        tests++;
        if (cap_str() != "E\n" || depth !== 4'd0 || err !== 1'b1) begin
            fails++;
            $display("FAIL overflow: got '%s' depth=%0d err=%b required 'E\\n' 0 1", esc(cap_str()), depth, err);
        end
        run_seq("+");
        tests++;
        if (cap_str() != "E\n" || depth !== 4'd0) begin
            fails++;
            $display("FAIL underflow_op: got '%s' depth=%0d required 'E\\n' 0", esc(cap_str()), depth);
        end
        run_seq("=");
        tests++;
        if (cap_str() != "E\n") begin
            fails++;
            $display("FAIL underflow_eq: got '%s' required 'E\\n'", esc(cap_str()));
        end
        run_seq("4x");
        tests++;
        if (cap_str() != "E\n" || err !== 1'b1) begin
            fails++;
            $display("FAIL bad_char: got '%s' err=%b required 'E\\n' 1", esc(cap_str()), err);
        end
    endtask

    task automatic test_stall();
        string req = "-997\n";
        byte   held;
        ack_mode = 2;
        man_ack = 1'b0;
        m_out = "";
        cap_q.delete();
        for (int i = 0; i < 8; i++) begin
            byte c;
            string s = "3 1000-=";
            c = s[i];
            m_char(c);
            send_char(c);
        end
        for (int k = 0; k < req.len(); k++) begin
            int n = 0;
            while (!out_stb && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            held = out_char;
            tests++;
            if (out_stb !== 1'b1 || held != req[k]) begin
                fails++;
                $display("FAIL stall_char_%0d: stb=%b char=%h required 1/%h", k, out_stb, held, req[k]);
            end
            for (int j = 0; j < 5; j++) begin
                @(posedge clk); #1;
                tests++;
                if (out_stb !== 1'b1 || out_char !== held || in_ack !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_hold_%0d: stb=%b char=%h in_ack=%b required 1/%h/0",
                             k, out_stb, out_char, in_ack, held);
                end
            end
            man_ack = 1'b1;
            @(posedge clk); #1;
            man_ack = 1'b0;
        end
        wait_idle();
        tests++;
        if (cap_str() != req || m_out != req) begin
            fails++;
            $display("FAIL stall_out: got '%s' required '%s'", esc(cap_str()), esc(req));
        end
        ack_mode = 0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        ack_mode = 2;
        man_ack = 1'b0;
        cap_q.delete();
        send_char("1"); send_char("2"); send_char("3"); send_char("4"); send_char("=");
        while (!out_stb && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        man_ack = 1'b1;
        @(posedge clk); #1;
        man_ack = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_stb !== 1'b0) begin fails++; $display("FAIL async_rst_stb: got %b required 0", out_stb); end
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b1;
        m_reset();
        @(posedge clk); #1;
        tests++;
        if (in_ack !== 1'b1 || depth !== 4'd0 || err !== 1'b0) begin
            fails++;
            $display("FAIL post_rst: in_ack=%b depth=%0d err=%b required 1/0/0", in_ack, depth, err);
        end
        ack_mode = 0;
        run_seq("9=");
        tests++;
        if (cap_str() != "9\n") begin
            fails++;
            $display("FAIL post_rst_run: got '%s' required '9\\n'", esc(cap_str()));
        end
    endtask

    task automatic test_random();
        string cs = "0123456789 0123456789  +-*/()=x";
        ack_mode = 1;
        for (int it = 0; it < 30; it++) begin
            string s = "";
            int len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) begin
                s = {s, $sformatf("%c", cs[$urandom_range(0, cs.len() - 1)])};
            end
            s = {s, "="};
            run_seq(s);
            tests++;
            if (cap_str() != m_out) begin
                fails++;
                $display("FAIL rand_out_%0d [%s]: got '%s' required '%s'", it, s, esc(cap_str()), esc(m_out));
            end
            tests++;
            if (err !== m_err || depth !== 4'(m_stk.size())) begin
                fails++;
                $display("FAIL rand_state_%0d [%s]: err=%b depth=%0d required %b/%0d",
                         it, s, err, depth, m_err, m_stk.size());
            end
        end
        ack_mode = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_arith();
        test_div_zero();
        test_overflow_underflow();
        test_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
